ras_ckpt_stack: RTL

//  Return-address stack for the fetch stage: circular LIFO of predicted return targets with a

---
 rtl/ras_pkg.sv | 26 ++
 rtl/ras_ckpt_file.sv | 35 +++
 rtl/ras_ckpt_stack.sv | 95 +++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// Shared sizing, snapshot type and modulo pointer helpers for the return-address stack.
package ras_pkg;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 16;
    localparam int NUM_CKPT = 4;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [CNT_W-1:0] count;
        logic [XLEN-1:0]  top;
    } ras_snap_t;

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return p - {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ras_ckpt_file.sv
// Checkpoint register file: NUM_CKPT snapshots, synchronous write, combinational read.
// Latency: write visible next cycle; read zero-latency.
// Backpressure: none, every write is accepted.
module ras_ckpt_file
    import ras_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_vld,
    input  logic [CKPT_W-1:0] wr_idx,
    input  ras_snap_t         wr_dat,
    input  logic [CKPT_W-1:0] rd_idx,
    output ras_snap_t         rd_dat
);

    ras_snap_t slots [NUM_CKPT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_vld && (32'(wr_idx) < NUM_CKPT)) begin
            slots[wr_idx] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat = '0;
        if (32'(rd_idx) < NUM_CKPT) begin
            rd_dat = slots[rd_idx];
        end
    end

endmodule

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with speculative checkpoints for fetch-stage return prediction.
// Latency: updates land on the next edge; top/empty/full/count are read straight from state.
// Backpressure: none; pushes when full overwrite the oldest entry, pops on empty flag underflow.
module ras_ckpt_stack
    import ras_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic              ckpt_save_i,
    input  logic              ckpt_restore_i,
    input  logic [CKPT_W-1:0] ckpt_id_i,
    output logic [XLEN-1:0]   top_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              underflow_o
);

    logic [XLEN-1:0]  entry [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic             id_ok;
    logic             restore_vld;
    logic             save_vld;
    ras_snap_t        save_dat;
    ras_snap_t        rest_dat;

    assign id_ok       = (32'(ckpt_id_i) < NUM_CKPT);
    assign restore_vld = ckpt_restore_i && id_ok;
    assign save_vld    = ckpt_save_i && id_ok && !ckpt_restore_i;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;
    assign top_o   = empty_o ? '0 : entry[ptr_dec(ptr)];

    assign save_dat = '{ptr: ptr, count: count, top: top_o};

    ras_ckpt_file u_ckpt_file (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_vld (save_vld),
        .wr_idx (ckpt_id_i),
        .wr_dat (save_dat),
        .rd_idx (ckpt_id_i),
        .rd_dat (rest_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr         <= '0;
            count       <= '0;
            underflow_o <= 1'b0;
        end else begin
            underflow_o <= 1'b0;
            if (restore_vld) begin
                ptr   <= rest_dat.ptr;
                count <= rest_dat.count;
            end else if (push_i && (!pop_i || empty_o)) begin
                ptr <= ptr_inc(ptr);
                if (!full_o) begin
                    count <= count + 1'b1;
                end
            end else if (pop_i && !push_i) begin
                if (!empty_o) begin
                    ptr   <= ptr_dec(ptr);
                    count <= count - 1'b1;
                end else begin
                    underflow_o <= 1'b1;
                end
            end
        end
    end

    // Entry storage is never reset; reads of unwritten slots are masked by count.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (restore_vld) begin
                if (rest_dat.count != '0) begin
                    entry[ptr_dec(rest_dat.ptr)] <= rest_dat.top;
                end
            end else if (push_i) begin
                if (pop_i && !empty_o) begin
                    entry[ptr_dec(ptr)] <= data_i;
                end else begin
                    entry[ptr] <= data_i;
                end
            end
        end
    end

endmodule
